// File: rtl/mole_pkg.sv
// Shared types and constants for the mole sequencer and its LFSR.
package mole_pkg;

  typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_e;

  localparam int unsigned NUM_MOLES = 5;

  // Fibonacci taps 8,6,5,4 mapped onto bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [2:0] pick_index(input logic [7:0] rnd, input logic [2:0] prev);
    logic [2:0] idx;
    idx = 3'(rnd % 8'(NUM_MOLES));
    if (idx == prev) idx = (idx == 3'(NUM_MOLES - 1)) ? 3'd0 : idx + 3'd1;
    return idx;
  endfunction

endpackage

// File: rtl/mole_sequencer_if.sv
// Player-facing signals of the mole sequencer: buttons/start in, LEDs and events out.
interface mole_sequencer_if;
  import mole_pkg::*;

  logic                 start_i;
  logic [NUM_MOLES-1:0] whack_i;
  logic [NUM_MOLES-1:0] LED_o;
  logic [4:0]           round_o;
  logic                 hit_o;
  logic                 miss_o;
  logic                 timeout_o;
  logic                 game_over_o;

  modport master (
    output start_i, whack_i,
    input  LED_o, round_o, hit_o, miss_o, timeout_o, game_over_o
  );

  modport slave (
    input  start_i, whack_i,
    output LED_o, round_o, hit_o, miss_o, timeout_o, game_over_o
  );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR with a reset seed.
module lfsr8
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/mole_sequencer.sv
// Whack-a-mole sequencer: chooses the lit mole, times it out, and counts rounds.
module mole_sequencer
  import mole_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned SHOW_TICKS = 2,
  parameter int unsigned GAP_TICKS  = 1,
  parameter int unsigned NUM_ROUNDS = 30,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic            MHz100_clk_i,
  input  logic            reset_n_i,
  mole_sequencer_if.slave bus
);

  localparam int unsigned SHOW_DUR = SHOW_TICKS * TICK_DIV;
  localparam int unsigned GAP_DUR  = GAP_TICKS * TICK_DIV;
  localparam int unsigned MAX_DUR  = (SHOW_DUR > GAP_DUR) ? SHOW_DUR : GAP_DUR;
  localparam int unsigned CNT_W    = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_DUR - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_DUR - 1);
  localparam logic [4:0]       LAST_ROUND = 5'(NUM_ROUNDS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_MOLES-1:0] led_q, led_d;
  logic [NUM_MOLES-1:0] whack_q, whack_d;
  logic [4:0]           round_q, round_d;
  logic [2:0]           prev_q, prev_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 timeout_q, timeout_d;
  logic                 game_over_q, game_over_d;
  logic [7:0]           lfsr_value;
  logic [2:0]           idx;
  logic [NUM_MOLES-1:0] rise;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (MHz100_clk_i),
    .rst_n   (reset_n_i),
    .value_o (lfsr_value)
  );

  assign rise = bus.whack_i & ~whack_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    round_d   = round_q;
    prev_d    = prev_q;
    whack_d   = bus.whack_i;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    timeout_d = 1'b0;
    idx       = pick_index(lfsr_value, prev_q);

    unique case (state_q)
      IDLE, DONE: begin
        led_d = '0;
        if (bus.start_i) begin
          round_d = '0;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        led_d  = '0;
        miss_d = |rise;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            led_d   = NUM_MOLES'(1) << idx;
            prev_d  = idx;
            round_d = round_q + 5'd1;
            state_d = SHOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHOW: begin
        // A hit outranks both a stray press and expiry in the same cycle.
        if (|(rise & led_q)) begin
          hit_d   = 1'b1;
          led_d   = '0;
          cnt_d   = '0;
          state_d = GAP;
        end else if (|rise) begin
          miss_d = 1'b1;
          if (cnt_q != SHOW_LAST) cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q == SHOW_LAST) begin
          timeout_d = 1'b1;
          led_d     = '0;
          cnt_d     = '0;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        led_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    game_over_d = (state_d == DONE);
  end

  always_ff @(posedge MHz100_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      led_q       <= '0;
      whack_q     <= '0;
      round_q     <= '0;
      prev_q      <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      timeout_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      whack_q     <= whack_d;
      round_q     <= round_d;
      prev_q      <= prev_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      timeout_q   <= timeout_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.LED_o       = led_q;
  assign bus.round_o     = round_q;
  assign bus.hit_o       = hit_q;
  assign bus.miss_o      = miss_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.game_over_o = game_over_q;

endmodule

// File: tb/tb_mole_sequencer.sv
// Directed bench for mole_sequencer; lit-mole choices come from a reference LFSR and a scoreboard queue.
module tb_mole_sequencer;

  localparam int unsigned TICK_DIV   = 2;
  localparam int unsigned SHOW_TICKS = 3;
  localparam int unsigned GAP_TICKS  = 2;
  localparam int unsigned NUM_ROUNDS = 3;
  localparam logic [7:0]  SEED       = 8'hA5;
  localparam int          SHOW_CYC   = 6;
  localparam int          GAP_CYC    = 4;

  typedef struct packed {
    logic [4:0] led;
    logic [4:0] round;
  } exp_t;

  logic clk;
  logic rst_n;

  mole_sequencer_if bus ();

  mole_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .SHOW_TICKS (SHOW_TICKS),
    .GAP_TICKS  (GAP_TICKS),
    .NUM_ROUNDS (NUM_ROUNDS),
    .LFSR_SEED  (SEED)
  ) dut (
    .MHz100_clk_i (clk),
    .reset_n_i    (rst_n),
    .bus          (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       sb[$];
  logic [7:0] m_lfsr;
  int         m_round  = 0;
  int         m_prev   = 0;
  logic [4:0] last_led = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR: taps 8,6,5,4, feedback shifted into bit 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [4:0] whack);
    bus.start_i = start;
    bus.whack_i = whack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gapPhase(input int miss_at);
    for (int c = 0; c < GAP_CYC; c++) begin
      checkOutput("gap_led", 32'(bus.LED_o), 32'd0);
      checkOutput("gap_round", 32'(bus.round_o), 32'(m_round));
      if (c > 0) begin
        checkOutput("gap_miss", 32'(bus.miss_o), 32'(miss_at >= 0 && c == miss_at + 1));
        checkOutput("gap_hit", 32'(bus.hit_o), 32'd0);
        checkOutput("gap_timeout", 32'(bus.timeout_o), 32'd0);
      end
      if (miss_at >= 0) bus.whack_i = (c == miss_at) ? 5'b00100 : 5'b00000;
      if (c == GAP_CYC - 1 && m_round < NUM_ROUNDS) begin
        int   idx;
        exp_t e;
        idx = int'(m_lfsr) % 5;
        if (idx == m_prev) idx = (idx + 1) % 5;
        m_prev  = idx;
        m_round = m_round + 1;
        e.led   = 5'(1 << idx);
        e.round = 5'(m_round);
        sb.push_back(e);
      end
      tick();
    end
  endtask

  task automatic enterShow(output exp_t e);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL sb_empty observed=0 expected=1");
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    checkOutput("show_first_led", 32'(bus.LED_o), 32'(e.led));
    checkOutput("show_round", 32'(bus.round_o), 32'(e.round));
    checkOutput("show_onehot", 32'($onehot(bus.LED_o)), 32'd1);
    checkOutput("show_differs", 32'(bus.LED_o != last_led), 32'd1);
    last_led = bus.LED_o;
  endtask

  task automatic showPhase(input int hit_at, input int miss_at, input bit all_bits);
    exp_t       e;
    logic [4:0] other;
    enterShow(e);
    other = (e.led == 5'b00001) ? 5'b00010 : 5'b00001;
    for (int c = 0; c < SHOW_CYC; c++) begin
      checkOutput("show_led", 32'(bus.LED_o), 32'(e.led));
      checkOutput("show_miss", 32'(bus.miss_o), 32'(miss_at >= 0 && c == miss_at + 1));
      checkOutput("show_hit", 32'(bus.hit_o), 32'd0);
      checkOutput("show_timeout", 32'(bus.timeout_o), 32'd0);
      if (c == hit_at)       bus.whack_i = all_bits ? 5'b11111 : e.led;
      else if (c == miss_at) bus.whack_i = other;
      else                   bus.whack_i = 5'b00000;
      tick();
      if (c == hit_at) break;
    end
    bus.whack_i = 5'b00000;
    checkOutput("end_led", 32'(bus.LED_o), 32'd0);
    checkOutput("end_hit", 32'(bus.hit_o), 32'(hit_at >= 0));
    checkOutput("end_timeout", 32'(bus.timeout_o), 32'(hit_at < 0));
    checkOutput("end_miss", 32'(bus.miss_o), 32'd0);
  endtask

  task automatic doneCheck();
    for (int c = 0; c < 2; c++) begin
      checkOutput("done_flag", 32'(bus.game_over_o), 32'd1);
      checkOutput("done_round", 32'(bus.round_o), 32'(NUM_ROUNDS));
      checkOutput("done_led", 32'(bus.LED_o), 32'd0);
      tick();
    end
  endtask

  task automatic startGame(input bit hold_start);
    applyStimulus(1'b1, 5'b00000);
    tick();
    if (!hold_start) applyStimulus(1'b0, 5'b00000);
    m_round = 0;
    checkOutput("start_round", 32'(bus.round_o), 32'd0);
    checkOutput("start_game_over", 32'(bus.game_over_o), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'b00000);
    #3 rst_n = 1'b0;
    #4;
    checkOutput("rst_led", 32'(bus.LED_o), 32'd0);
    checkOutput("rst_round", 32'(bus.round_o), 32'd0);
    checkOutput("rst_hit", 32'(bus.hit_o), 32'd0);
    checkOutput("rst_miss", 32'(bus.miss_o), 32'd0);
    checkOutput("rst_timeout", 32'(bus.timeout_o), 32'd0);
    checkOutput("rst_game_over", 32'(bus.game_over_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("idle_led", 32'(bus.LED_o), 32'd0);
      checkOutput("idle_game_over", 32'(bus.game_over_o), 32'd0);
    end

    $display("[TB] Game 1: three unhit moles time out");
    startGame(1'b0);
    for (int r = 0; r < NUM_ROUNDS; r++) begin
      gapPhase(-1);
      showPhase(-1, -1, 1'b0);
    end
    gapPhase(-1);
    doneCheck();

    $display("[TB] Game 2: hit, miss in SHOW, miss in GAP, hit at expiry");
    startGame(1'b1);
    gapPhase(-1);
    applyStimulus(1'b0, 5'b00000);
    showPhase(2, -1, 1'b0);
    gapPhase(-1);
    showPhase(-1, 1, 1'b0);
    gapPhase(1);
    showPhase(5, -1, 1'b1);
    gapPhase(-1);
    doneCheck();

    $display("[TB] Game 3: buttons held across rounds, then reset mid-SHOW");
    startGame(1'b0);
    gapPhase(-1);
    enterShow(e);
    tick();
    bus.whack_i = 5'b11111;
    tick();
    checkOutput("hold_hit", 32'(bus.hit_o), 32'd1);
    checkOutput("hold_miss", 32'(bus.miss_o), 32'd0);
    checkOutput("hold_led", 32'(bus.LED_o), 32'd0);
    gapPhase(-1);
    enterShow(e);
    for (int c = 0; c < 4; c++) begin
      checkOutput("held_led", 32'(bus.LED_o), 32'(e.led));
      checkOutput("held_hit", 32'(bus.hit_o), 32'd0);
      checkOutput("held_miss", 32'(bus.miss_o), 32'd0);
      if (c == 2)      bus.whack_i = 5'b00000;
      else if (c == 3) bus.whack_i = e.led;
      tick();
    end
    checkOutput("repress_hit", 32'(bus.hit_o), 32'd1);
    checkOutput("repress_led", 32'(bus.LED_o), 32'd0);
    checkOutput("repress_timeout", 32'(bus.timeout_o), 32'd0);
    bus.whack_i = 5'b00000;
    gapPhase(-1);
    enterShow(e);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_led", 32'(bus.LED_o), 32'd0);
    checkOutput("midrst_round", 32'(bus.round_o), 32'd0);
    checkOutput("midrst_game_over", 32'(bus.game_over_o), 32'd0);
    tick();
    checkOutput("midrst_hold_led", 32'(bus.LED_o), 32'd0);
    rst_n    = 1'b1;
    m_prev   = 0;
    m_round  = 0;
    last_led = '0;
    sb.delete();
    tick();
    checkOutput("post_rst_led", 32'(bus.LED_o), 32'd0);
    startGame(1'b0);
    gapPhase(-1);
    showPhase(-1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
